// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter, one bit position per clock
// Optional feature macro: SEQ_SHIFT_ROTATE_EN (Op 0011 rotate left, Op 0111 rotate right)
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, sampled only while idle
//   B, Sa, Op, Cin     operand, shift amount, opcode, fill bit (latched on start)
//   busy, done         in-progress flag, one-cycle completion pulse
//   fout, Cout         shifted result, last bit shifted out
module seq_shift_unit #(
  parameter int WIDTH = 4,
  parameter int SA_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] B,
  input  logic [SA_W-1:0]  Sa,
  input  logic [3:0]       Op,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] fout,
  output logic             Cout
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SA_W-1:0]  count_q, count_d;
  logic [3:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One-position step of the latched operation; decode uses only latched copies.
  logic [WIDTH-1:0] step_reg;
  logic             step_out;

  always_comb begin
    step_reg = sreg_q;
    step_out = 1'b0;
    if (op_q == 4'b0101) begin
      step_reg = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
      step_out = sreg_q[0];
    end
`ifdef SEQ_SHIFT_ROTATE_EN
    else if (op_q == 4'b0011) begin
      step_reg = {sreg_q[WIDTH-2:0], sreg_q[WIDTH-1]};
      step_out = sreg_q[WIDTH-1];
    end
    else if (op_q == 4'b0111) begin
      step_reg = {sreg_q[0], sreg_q[WIDTH-1:1]};
      step_out = sreg_q[0];
    end
`endif
    else if (op_q[2]) begin
      step_reg = {cin_q, sreg_q[WIDTH-1:1]};
      step_out = sreg_q[0];
    end
    else begin
      step_reg = {sreg_q[WIDTH-2:0], cin_q};
      step_out = sreg_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    count_d = count_q;
    op_d    = op_q;
    cin_d   = cin_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = B;
          count_d = Sa;
          op_d    = Op;
          cin_d   = Cin;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q != '0) begin
          sreg_d  = step_reg;
          cout_d  = step_out;
          count_d = count_q - 1'b1;
        end else begin
          // Completion takes its own cycle, giving Sa+1 cycles of latency.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      count_q <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      count_q <= count_d;
      op_q    <= op_d;
      cin_q   <= cin_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign fout = sreg_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - self-checking bench for seq_shift_unit
module tb_seq_shift_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] B;
  logic [1:0] Sa;
  logic [3:0] Op;
  logic       Cin;
  logic       busy;
  logic       done;
  logic [3:0] fout;
  logic       Cout;

  int total = 0;
  int bad   = 0;

  seq_shift_unit #(.WIDTH(4), .SA_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .B(B), .Sa(Sa), .Op(Op), .Cin(Cin),
    .busy(busy), .done(done), .fout(fout), .Cout(Cout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [3:0] b;
    logic [1:0] sa;
    logic [3:0] op;
    logic       cin;
    logic [3:0] f;
    logic       c;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: shift the whole operand n places at once with integer arithmetic.
  function automatic void model(input logic [3:0] b, input int n, input logic [3:0] op,
                                input logic cin, output logic [3:0] f, output logic c);
    int v;
    int r;
    logic [3:0] bb;
    v  = int'(b);
    bb = b;
    r  = v;
    c  = 1'b0;
    if (n == 0) begin
      f = b;
      return;
    end
    if (op == 4'b0101) begin
      r = v >> n;
      if (bb[3]) r = r | ((15 << (4 - n)) & 15);
      c = bb[n-1];
    end
`ifdef SEQ_SHIFT_ROTATE_EN
    else if (op == 4'b0011) begin
      r = ((v << n) | (v >> (4 - n))) & 15;
      c = bb[4-n];
    end
    else if (op == 4'b0111) begin
      r = ((v >> n) | (v << (4 - n))) & 15;
      c = bb[n-1];
    end
`endif
    else if (op[2]) begin
      r = (v >> n) | (cin ? ((15 << (4 - n)) & 15) : 0);
      c = bb[n-1];
    end else begin
      r = ((v << n) & 15) | (cin ? ((1 << n) - 1) : 0);
      c = bb[4-n];
    end
    f = 4'(r);
  endfunction

  // Launch one operation, scramble inputs after the start edge, wait for done.
  task automatic run_op(input logic [3:0] b, input logic [1:0] sa, input logic [3:0] op,
                        input logic cin, output int lat, output logic busy_ok);
    @(negedge clk);
    B = b; Sa = sa; Op = op; Cin = cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    B = 4'($urandom); Sa = 2'($urandom); Op = 4'($urandom); Cin = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic bok;
    logic [3:0] ef;
    logic ec;
    int seen;

    rst_n = 1'b0; start = 1'b0; B = '0; Sa = '0; Op = '0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset fout", int'(fout), 0);
    check("reset cout", int'(Cout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"left 1011 sa2 cin1",   4'b1011, 2'd2, 4'b0000, 1'b1, 4'b1111, 1'b0});
    vecs.push_back('{"lsr 1011 sa1",         4'b1011, 2'd1, 4'b0100, 1'b0, 4'b0101, 1'b1});
    vecs.push_back('{"asr 1000 sa3",         4'b1000, 2'd3, 4'b0101, 1'b0, 4'b1111, 1'b0});
    vecs.push_back('{"asr 0110 sa3",         4'b0110, 2'd3, 4'b0101, 1'b0, 4'b0000, 1'b1});
    vecs.push_back('{"left 1010 sa0",        4'b1010, 2'd0, 4'b0000, 1'b0, 4'b1010, 1'b0});
    vecs.push_back('{"lsr 0000 cin1 sa3",    4'b0000, 2'd3, 4'b0110, 1'b1, 4'b1110, 1'b0});
    vecs.push_back('{"left op1000 0001 sa3", 4'b0001, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b0});
    vecs.push_back('{"lsr op1101 1000 sa1",  4'b1000, 2'd1, 4'b1101, 1'b1, 4'b1100, 1'b0});
`ifdef SEQ_SHIFT_ROTATE_EN
    vecs.push_back('{"rol 1001 sa1",         4'b1001, 2'd1, 4'b0011, 1'b0, 4'b0011, 1'b1});
    vecs.push_back('{"ror 1001 sa2",         4'b1001, 2'd2, 4'b0111, 1'b0, 4'b0110, 1'b0});
`else
    vecs.push_back('{"op0011 1001 sa1",      4'b1001, 2'd1, 4'b0011, 1'b0, 4'b0010, 1'b1});
    vecs.push_back('{"op0111 1001 sa2",      4'b1001, 2'd2, 4'b0111, 1'b0, 4'b0010, 1'b0});
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].b, vecs[i].sa, vecs[i].op, vecs[i].cin, lat, bok);
      check({vecs[i].name, " done"}, int'(done), 1);
      check({vecs[i].name, " latency"}, lat, int'(vecs[i].sa) + 1);
      check({vecs[i].name, " busy during"}, int'(bok), 1);
      check({vecs[i].name, " busy at done"}, int'(busy), 0);
      check({vecs[i].name, " fout"}, int'(fout), int'(vecs[i].f));
      check({vecs[i].name, " cout"}, int'(Cout), int'(vecs[i].c));
    end

    // Start held through busy is ignored; start in the done cycle is accepted.
    @(negedge clk);
    B = 4'b1010; Sa = 2'd0; Op = 4'b0000; Cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    B = 4'b0001; Sa = 2'd1;
    check("b2b busy", int'(busy), 1);
    @(posedge clk); #1;
    check("b2b first done", int'(done), 1);
    check("b2b first fout", int'(fout), 4'b1010);
    check("b2b first cout", int'(Cout), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b accepted busy", int'(busy), 1);
    check("b2b accepted done low", int'(done), 0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b second done", int'(done), 1);
    check("b2b second latency", lat, 2);
    check("b2b second fout", int'(fout), 4'b0010);
    check("b2b second cout", int'(Cout), 0);

    // Reset mid-operation aborts with no later done pulse.
    @(negedge clk);
    B = 4'b1011; Sa = 2'd3; Op = 4'b0000; Cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort fout", int'(fout), 0);
    check("abort cout", int'(Cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no done", seen, 0);

    // Random operations against the whole-shift reference.
    for (int k = 0; k < 60; k++) begin
      logic [3:0] rb;
      logic [1:0] rsa;
      logic [3:0] rop;
      logic       rcin;
      rb = 4'($urandom); rsa = 2'($urandom); rcin = 1'($urandom);
      rop = ($urandom_range(3, 0) == 0) ? 4'b0101 : 4'($urandom);
      model(rb, int'(rsa), rop, rcin, ef, ec);
      run_op(rb, rsa, rop, rcin, lat, bok);
      check($sformatf("rand%0d b=%h sa=%0d op=%h cin=%0d latency", k, rb, rsa, rop, rcin), lat, int'(rsa) + 1);
      check($sformatf("rand%0d busy", k), int'(bok), 1);
      check($sformatf("rand%0d fout", k), int'(fout), int'(ef));
      check($sformatf("rand%0d cout", k), int'(Cout), int'(ec));
      @(posedge clk); #1;
      check($sformatf("rand%0d done pulse", k), int'(done), 0);
      check($sformatf("rand%0d fout hold", k), int'(fout), int'(ef));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
- Multi-cycle shift engine; moves the operand one bit position per clock for Sa clocks.
- Captures the bit shifted out on each step; the last one is presented as Cout.
- Same opcode/fill conventions as the combinational shifter path.
- Sits beside the ALU shifter for paths that need a registered result, a busy/done handshake, and the shifted-out carry.

Parameters:
- WIDTH, 4, operand/result width in bits.
- SA_W, 2, width of shift-amount input Sa; maximum shift is 2^SA_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- B  input  WIDTH  operand to shift.
- Sa  input  SA_W  number of bit positions to shift.
- Op  input  4  opcode. Op[2]=0 left, Op[2]=1 right; Op==4'b0101 arithmetic right.
- Cin  input  1  fill bit for vacated positions (non-arithmetic ops).
- busy  output  1  high while the operation is in progress.
- done  output  1  one-cycle pulse; fout/Cout valid.
- fout  output  WIDTH  shifted result, held until the next accepted start.
- Cout  output  1  last bit shifted out; 0 if Sa==0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, fout=0, Cout=0, count=0, latched op=0.
- States: IDLE, SHIFT.
- IDLE:
  - start=1 at an edge latches B into the shift register, Sa into count, and Op and Cin.
  - At the same edge: Cout<=0, busy<=1, state->SHIFT.
  - start=0 leaves all outputs unchanged.
- SHIFT, count!=0, one step per edge, then count decrements:
  - Left (Op[2]=0): reg<={reg[W-2:0],Cin}, Cout<=reg[W-1].
  - Logical right (Op[2]=1, Op!=0101): reg<={Cin,reg[W-1:1]}, Cout<=reg[0].
  - Arithmetic right (Op==0101): reg<={reg[W-1],reg[W-1:1]}, Cout<=reg[0]; Cin ignored.
- SHIFT, count==0: done<=1, busy<=0, state->IDLE.
- done is high for exactly one cycle.
- fout is driven directly from the shift register. It is valid when done=1 and holds until the next accepted start.
- Latency: done is asserted Sa+1 cycles after the edge that samples start (Sa=0 gives 1 cycle, Sa=3 gives 4 cycles).
- start while busy: ignored; the latched operands stay unchanged.
- start in the done cycle is accepted; back-to-back operation is legal.
- B, Sa, Op, Cin may change freely after the start edge; only latched copies are used.
- Opcodes with Op[2]=1 other than 0101 behave as logical right; Op[2]=0 behaves as left (Op[3], Op[1:0] ignored unless the optional feature is enabled).
- Reset asserted mid-operation aborts immediately to the reset values; no done pulse.

Optional Feature:
- Macro: SEQ_SHIFT_ROTATE_EN.
- Defined:
  - Op==4'b0011 rotates left: reg<={reg[W-2:0],reg[W-1]}, Cout<=reg[W-1].
  - Op==4'b0111 rotates right: reg<={reg[0],reg[W-1:1]}, Cout<=reg[0].
  - Cin is ignored for both rotates.
- Not defined: 0011 is a plain left shift and 0111 a plain logical right shift, per the rules above.

Test Plan:
- Left: B=1011, Op=0000, Cin=1, Sa=2, start -> done 3 cycles later; fout=1111, Cout=0; busy high for the 3 cycles before done.
- Logical right: B=1011, Op=0100, Cin=0, Sa=1 -> done 2 cycles later; fout=0101, Cout=1.
- Arithmetic right: B=1000, Op=0101, Cin=0, Sa=3 -> done 4 cycles later; fout=1111, Cout=0. Also B=0110, Sa=3 -> fout=0000, Cout=1.
- Sa=0, B=1010, Op=0000 -> done 1 cycle after start; fout=1010, Cout=0. Then: start held high during busy with B=0001 -> ignored; start in done cycle with B=0001, Sa=1, Op=0000, Cin=0 -> accepted, fout=0010.
- Reset mid-op: Sa=3 start, drop rst_n after 2 cycles -> busy=0, done=0, fout=0, Cout=0 immediately; no done pulse after release.
- SEQ_SHIFT_ROTATE_EN:
  - Defined: B=1001, Op=0011, Sa=1 -> fout=0011, Cout=1.
  - Not defined, same stimulus with Cin=0 -> fout=0010, Cout=1.
